// File: rtl/fault_monitor.sv
// fault_monitor: detects rising edges on N fault lines, keeps saturating per-line
// event counters and queues timestamped event records in a show-ahead FIFO.
// Optional glitch filter: define FAULT_MON_GLITCH_FILTER_EN to require a line to be
// high for two consecutive samples before it counts as an event.
module fault_monitor #(
    parameter int unsigned N          = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TS_W       = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         fault_i,
    input  logic                 arm_i,
    input  logic                 clear_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [N-1:0]         evt_mask_o,
    output logic [TS_W-1:0]      evt_ts_o,
    output logic [N*CNT_W-1:0]   fault_cnt_o,
    output logic                 overflow_o,
    output logic [1:0]           state_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = N + TS_W;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StArmed    = 2'b01,
        StOverflow = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      s1_q, s2_q;
`ifdef FAULT_MON_GLITCH_FILTER_EN
    logic [N-1:0]      s3_q;
`endif
    logic [N-1:0]      rise;
    logic [TS_W-1:0]   ts_q;
    logic [CNT_W-1:0]  cnt_q [N];
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              overflow_q;
    logic              fifo_full, fifo_empty;
    logic              pop, wr_req, wr_en, drop, count_en;
    logic [EW-1:0]     head;

    // Input sampling chain, runs in every state so arming never sees a stale low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
`ifdef FAULT_MON_GLITCH_FILTER_EN
            s3_q <= '0;
`endif
        end else begin
            s1_q <= fault_i;
            s2_q <= s1_q;
`ifdef FAULT_MON_GLITCH_FILTER_EN
            s3_q <= s2_q;
`endif
        end
    end

    // Per-line rising-edge detect.
    always_comb begin
`ifdef FAULT_MON_GLITCH_FILTER_EN
        rise = s1_q & s2_q & ~s3_q;
`else
        rise = s1_q & ~s2_q;
`endif
    end

    // FIFO depth is a power of two, so the count MSB alone marks full.
    assign fifo_full  = count_q[AW];
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & evt_ready_i;
    assign wr_req     = (state_q == StArmed) & (|rise) & ~clear_i;
    assign wr_en      = wr_req & (~fifo_full | pop);
    assign drop       = wr_req & fifo_full & ~pop;
    assign count_en   = ((state_q == StArmed) | (state_q == StOverflow)) & ~clear_i;

    // Free-running timestamp; wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q <= '0;
        end else if (clear_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arm_i) state_d = StArmed;
            end
            StArmed: begin
                if (drop)        state_d = StOverflow;
                else if (!arm_i) state_d = StIdle;
            end
            StOverflow: begin
                state_d = StOverflow;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (clear_i) state_d = StIdle;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating per-line event counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
        end else if (count_en) begin
            for (int i = 0; i < int'(N); i++) begin
                if (rise[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop)      count_q <= count_q + 1'b1;
            else if (!wr_en && pop) count_q <= count_q - 1'b1;
        end
    end

    // FIFO storage; contents are only visible while valid, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= {rise, ts_q};
    end

    // Sticky drop flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // Output packing; head fields forced to zero while the FIFO is empty.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        evt_valid_o = ~fifo_empty;
        evt_mask_o  = fifo_empty ? '0 : head[EW-1:TS_W];
        evt_ts_o    = fifo_empty ? '0 : head[TS_W-1:0];
        fault_cnt_o = '0;
        for (int i = 0; i < int'(N); i++) fault_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
        overflow_o  = overflow_q;
        state_o     = state_q;
    end

endmodule

// File: tb/tb_fault_monitor.sv
// Directed bench for fault_monitor (N=4, CNT_W=4, TS_W=32, FIFO_DEPTH=8).
module tb_fault_monitor;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int TS_W  = 32;
    localparam int DEPTH = 8;
`ifdef FAULT_MON_GLITCH_FILTER_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [N-1:0]       fault_i;
    logic               arm_i;
    logic               clear_i;
    logic               evt_valid_o;
    logic               evt_ready_i;
    logic [N-1:0]       evt_mask_o;
    logic [TS_W-1:0]    evt_ts_o;
    logic [N*CNT_W-1:0] fault_cnt_o;
    logic               overflow_o;
    logic [1:0]         state_o;

    int errors = 0;
    int checks = 0;

    logic [TS_W-1:0]  ref_ts;
    logic [CNT_W-1:0] exp_cnt [N];
    bit               counting;
    logic [N-1:0]     q_mask [$];
    logic [TS_W-1:0]  q_ts [$];
    logic [TS_W-1:0]  t_evt;

    fault_monitor #(
        .N          (N),
        .CNT_W      (CNT_W),
        .TS_W       (TS_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fault_i     (fault_i),
        .arm_i       (arm_i),
        .clear_i     (clear_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_mask_o  (evt_mask_o),
        .evt_ts_o    (evt_ts_o),
        .fault_cnt_o (fault_cnt_o),
        .overflow_o  (overflow_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference timestamp: cycles since reset or last clear.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        ref_ts <= '0;
        else if (clear_i) ref_ts <= '0;
        else              ref_ts <= ref_ts + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int i);
        return fault_cnt_o[i*CNT_W +: CNT_W];
    endfunction

    task automatic check_counters(input string tag);
        for (int i = 0; i < N; i++) check($sformatf("%s cnt%0d", tag, i), cnt_of(i), exp_cnt[i]);
    endtask

    // Two-cycle pulse then idle; mode 0: ready low, 1: ready only on the write edge,
    // 2: ready high throughout. rec queues the expected FIFO entry.
    task automatic pulse(input logic [N-1:0] m, input int mode, input bit rec);
        logic [TS_W-1:0] tw;
        tw = '0;
        for (int c = 0; c < 5; c++) begin
            fault_i     = (c < 2) ? m : '0;
            evt_ready_i = (mode == 2) || (mode == 1 && c == LAT);
            tick();
            if (c == LAT - 1) tw = ref_ts;
        end
        evt_ready_i = 1'b0;
        if (counting) begin
            for (int i = 0; i < N; i++)
                if (m[i] && exp_cnt[i] != '1) exp_cnt[i] = exp_cnt[i] + 1'b1;
        end
        if (rec) begin
            q_mask.push_back(m);
            q_ts.push_back(tw);
        end
    endtask

    task automatic drain(input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s valid%0d", tag, j), evt_valid_o, 1'b1);
            check($sformatf("%s mask%0d", tag, j), evt_mask_o, q_mask.pop_front());
            check($sformatf("%s ts%0d", tag, j), evt_ts_o, q_ts.pop_front());
            evt_ready_i = 1'b1;
            tick();
            evt_ready_i = 1'b0;
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        fault_i     = 4'hF;
        arm_i       = 1'b0;
        clear_i     = 1'b0;
        evt_ready_i = 1'b0;
        counting    = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
        repeat (3) tick();
        rst_i = 1'b0;

        // Reset values
        check("rst state", state_o, 2'b00);
        check("rst valid", evt_valid_o, 1'b0);
        check("rst overflow", overflow_o, 1'b0);
        check("rst mask", evt_mask_o, '0);
        check("rst ts", evt_ts_o, '0);
        check_counters("rst");

        // Unarmed: lines high and a fresh pulse both ignored
        repeat (2) tick();
        fault_i = '0;
        repeat (3) tick();
        pulse(4'h5, 0, 1'b0);
        check("idle valid", evt_valid_o, 1'b0);
        check("idle state", state_o, 2'b00);
        check_counters("idle");

        // Arming while lines already high produces no event
        fault_i = 4'hF;
        repeat (3) tick();
        arm_i = 1'b1;
        tick();
        counting = 1'b1;
        check("arm state", state_o, 2'b01);
        repeat (3) tick();
        check("arm-high valid", evt_valid_o, 1'b0);
        check_counters("arm-high");
        fault_i = '0;
        repeat (4) tick();

        // Single one-cycle pulse on line 2, exact latency
        fault_i = 4'b0100;
        tick();
        t_evt   = ref_ts;
        fault_i = '0;
        check("single pre valid", evt_valid_o, 1'b0);
        tick();
`ifdef FAULT_MON_GLITCH_FILTER_EN
        repeat (3) tick();
        check("glitch valid", evt_valid_o, 1'b0);
`else
        exp_cnt[2] = 1;
        check("single valid", evt_valid_o, 1'b1);
        check("single mask", evt_mask_o, 4'b0100);
        check("single ts", evt_ts_o, t_evt);
`endif
        check_counters("single");
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        check("single popped", evt_valid_o, 1'b0);
        repeat (3) tick();

        // Simultaneous lines share one entry
        pulse(4'b1001, 0, 1'b1);
        drain(1, "simul");
        check("simul empty", evt_valid_o, 1'b0);
        check_counters("simul");

        // Overflow: nine edge cycles, eight stored
        for (int i = 0; i < 9; i++) begin
            pulse(4'(i + 1), 0, i < 8);
            if (i == 7) begin
                check("pre-ovf state", state_o, 2'b01);
                check("pre-ovf flag", overflow_o, 1'b0);
            end
        end
        check("ovf flag", overflow_o, 1'b1);
        check("ovf state", state_o, 2'b10);
        check_counters("ovf");
        arm_i = 1'b0;
        tick();
        check("ovf ignores arm", state_o, 2'b10);
        drain(8, "ovf");
        check("ovf drained", evt_valid_o, 1'b0);
        check("ovf still", state_o, 2'b10);
        clear_i = 1'b1;
        tick();
        clear_i  = 1'b0;
        counting = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
        check("clear state", state_o, 2'b00);
        check("clear flag", overflow_o, 1'b0);
        check("clear valid", evt_valid_o, 1'b0);
        check_counters("clear");

        // Full FIFO plus simultaneous pop
        arm_i = 1'b1;
        tick();
        counting = 1'b1;
        for (int i = 0; i < 8; i++) pulse(4'(i + 1), 0, 1'b1);
        pulse(4'hA, 1, 1'b1);
        void'(q_mask.pop_front());
        void'(q_ts.pop_front());
        check("fullpop flag", overflow_o, 1'b0);
        check("fullpop state", state_o, 2'b01);
        drain(8, "fullpop");
        check("fullpop empty", evt_valid_o, 1'b0);

        // Counter saturation with the consumer always ready
        repeat (20) pulse(4'h2, 2, 1'b0);
        check_counters("sat");
        check("sat empty", evt_valid_o, 1'b0);
        check("sat flag", overflow_o, 1'b0);

        // Backpressure keeps head stable
        pulse(4'h4, 0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            check("hold valid", evt_valid_o, 1'b1);
            check("hold mask", evt_mask_o, q_mask[0]);
            check("hold ts", evt_ts_o, q_ts[0]);
            tick();
        end
        drain(1, "hold");
        check("hold empty", evt_valid_o, 1'b0);

        // Asynchronous reset mid-operation
        pulse(4'h8, 0, 1'b1);
        check("pre-rst valid", evt_valid_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        counting = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
        q_mask.delete();
        q_ts.delete();
        check("mid-rst state", state_o, 2'b00);
        check("mid-rst valid", evt_valid_o, 1'b0);
        check("mid-rst ts", evt_ts_o, '0);
        check_counters("mid-rst");
        tick();
        rst_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
